// File: rtl/if_spike_decoder_if.sv
// Bundle of spike-side inputs and decoded outputs shared by the spike decoder and its driver.
// The master drives the spike stream and controls; the slave is the decoder.
interface if_spike_decoder_if #(
    parameter int RATE_W = 8,
    parameter int ISI_W  = 8
);
    logic              ena;
    logic              spike_in;
    logic [2:0]        window_sel;
    logic [RATE_W-1:0] rate;
    logic              rate_valid;
    logic [ISI_W-1:0]  isi;
    logic              isi_valid;

    modport master (
        output ena,
        output spike_in,
        output window_sel,
        input  rate,
        input  rate_valid,
        input  isi,
        input  isi_valid
    );

    modport slave (
        input  ena,
        input  spike_in,
        input  window_sel,
        output rate,
        output rate_valid,
        output isi,
        output isi_valid
    );
endinterface

// File: rtl/if_spike_decoder.sv
// Decodes an integrate-and-fire spike stream into a windowed spike rate and the latest
// inter-spike interval, both as registered values with one-cycle valid strobes.
module if_spike_decoder #(
    parameter int RATE_W = 8,
    parameter int ISI_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_spike_decoder_if.slave     bus
);
    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    localparam logic [RATE_W-1:0] RATE_MAX = '1;
    localparam logic [ISI_W-1:0]  ISI_MAX  = '1;

    state_t            state_q, state_d;
    logic [10:0]       wc_q, wc_d;
    logic [RATE_W-1:0] sc_q, sc_d;
    logic [2:0]        win_q, win_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0]  g_q, g_d;
    logic              seen_q, seen_d;
    logic [ISI_W-1:0]  isi_q, isi_d;
    logic              isi_valid_q, isi_valid_d;

    logic [10:0]       wc_last;
    logic [RATE_W-1:0] sc_sum;
    logic [ISI_W-1:0]  g_inc;

    // Window length is 16 << win_q; for win_q=7 the 2048 wraps out of 11 bits,
    // so the minus-one is taken at 12 bits before truncating to give 2047.
    assign wc_last = 11'((12'd16 << win_q) - 12'd1);
    assign sc_sum  = (bus.spike_in && (sc_q != RATE_MAX)) ? sc_q + 1'b1 : sc_q;
    assign g_inc   = (g_q != ISI_MAX) ? g_q + 1'b1 : g_q;

    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        sc_d         = sc_q;
        win_d        = win_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ena) begin
                    state_d = COUNT;
                    wc_d    = 11'd1;
                    sc_d    = RATE_W'(bus.spike_in);
                    win_d   = bus.window_sel;
                end else begin
                    wc_d = '0;
                    sc_d = '0;
                end
            end
            COUNT: begin
                if (!bus.ena) begin
                    state_d = IDLE;
                    wc_d    = '0;
                    sc_d    = '0;
                end else if (wc_q == wc_last) begin
                    // Closing edge: this sample is still part of the finishing window.
                    rate_d       = sc_sum;
                    rate_valid_d = 1'b1;
                    wc_d         = '0;
                    sc_d         = '0;
                    win_d        = bus.window_sel;
                end else begin
                    wc_d = wc_q + 11'd1;
                    sc_d = sc_sum;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        g_d         = g_q;
        seen_d      = seen_q;
        isi_d       = isi_q;
        isi_valid_d = 1'b0;
        if (!bus.ena) begin
            g_d    = '0;
            seen_d = 1'b0;
        end else if (bus.spike_in) begin
            if (seen_q) begin
                isi_d       = g_q;
                isi_valid_d = 1'b1;
            end
            g_d    = ISI_W'(1);
            seen_d = 1'b1;
        end else begin
            g_d = g_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wc_q         <= '0;
            sc_q         <= '0;
            win_q        <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            g_q          <= '0;
            seen_q       <= 1'b0;
            isi_q        <= '0;
            isi_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            sc_q         <= sc_d;
            win_q        <= win_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            g_q          <= g_d;
            seen_q       <= seen_d;
            isi_q        <= isi_d;
            isi_valid_q  <= isi_valid_d;
        end
    end

    assign bus.rate       = rate_q;
    assign bus.rate_valid = rate_valid_q;
    assign bus.isi        = isi_q;
    assign bus.isi_valid  = isi_valid_q;
endmodule

// File: doc/if_spike_decoder.md
# if_spike_decoder

Rate and interval decoder for the spike train produced by the integrate-and-fire neuron. It sits downstream of the neuron's spike output, on the same clock. It turns the 1-bit spike stream back into two numeric values:
- a spike count per programmable window (rate code);
- the most recent inter-spike interval (timing code).

Both are registered outputs with one-cycle valid strobes.

## Interface
Parameters:
- RATE_W, 8: width of the rate output; the spike count saturates at 2^RATE_W-1.
- ISI_W, 8: width of the interval output; the interval saturates at 2^ISI_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  decoder enable; low = IDLE.
- spike_in  in  1  spike from neuron, synchronous to clk, one bit per cycle.
- window_sel  in  3  window length N = 16 << window_sel cycles (16..2048).
- rate  out  RATE_W  spike count of the last completed window, saturated.
- rate_valid  out  1  one-cycle pulse when rate updates.
- isi  out  ISI_W  cycles between the last two spikes, saturated.
- isi_valid  out  1  one-cycle pulse when isi updates.

## Operation
Rate FSM, states IDLE and COUNT:
- IDLE, ena=0:
  - window counter wc=0, spike counter sc=0;
  - rate holds its value; rate_valid=0.
- IDLE, ena=1 at an edge:
  - move to COUNT;
  - this edge is sample 1 of the window: wc<=1, sc<=spike_in;
  - window_sel is latched as win_q.
- COUNT, ena=1, each edge:
  - if wc == N(win_q)-1: this is sample N. rate<=sat(sc+spike_in), rate_valid<=1, wc<=0, sc<=0, and window_sel is re-latched for the next window. Windows are back-to-back with no gap.
  - otherwise: wc<=wc+1, sc<=sat(sc+spike_in), rate_valid<=0.
- COUNT, ena=0 at an edge:
  - go to IDLE and discard the partial window;
  - no rate_valid; rate unchanged.
- Rule: a window covers exactly N sampled cycles.
- Rule: changing window_sel mid-window has no effect until the next window starts.

ISI path (independent of the FSM, active only while ena=1):
- Gap counter g: saturating counter of width ISI_W. It increments every enabled cycle and sticks at its maximum.
- Flag seen: 0 after reset or after ena=0.
- When spike_in=1:
  - if seen=1: isi<=g, isi_valid<=1;
  - in all cases: g<=1, seen<=1.
- Rule: spikes at edges t and t+k give isi=k. Back-to-back spikes give isi=1.
- Rule: isi = 2^ISI_W-1 means "at least that long".
- ena=0: g=0, seen=0, isi_valid=0, isi holds.

Width and arithmetic rules:
- wc is 11 bits.
- sc saturates at 2^RATE_W-1; it never wraps.
- g never wraps.

## Timing
- Reset (rst_n=0): immediately, without waiting for a clock edge, all of these are 0: rate, rate_valid, isi, isi_valid, wc, sc, g, seen, win_q. FSM goes to IDLE.
- Reset deasserted with ena=1: the first rising edge is sample 1.
- Latency:
  - rate/rate_valid update on the same edge that samples cycle N;
  - isi/isi_valid update on the edge that samples the spike.
- Simultaneous events:
  - a spike on the window-closing edge is counted in the closing window;
  - that spike also produces isi_valid on the same edge, so rate_valid and isi_valid may both be high.
- Valid pulses are one cycle wide; there is no backpressure.
- The next rate_valid after a window close comes exactly N edges later, if ena stays high.

## Test plan
- window_sel=0, spike_in=1 continuously, ena=1 → rate=16, rate_valid pulses every 16 cycles, isi=1 with isi_valid every cycle from the 2nd edge.
- window_sel=1, one spike every 4 cycles starting on sample 1 → rate=8 each window, isi=4 with isi_valid on every spike except the first.
- window_sel=7, spike_in=1 continuously → rate=255 (saturated) at edge 2048, then again every 2048 cycles.
- One spike, 300 idle cycles, one spike → isi=255, isi_valid once; a third spike 10 cycles later → isi=10.
- Prior rate=5; ena low at sample 10 of a 16-cycle window → no rate_valid, rate stays 5. Re-enable → the next rate_valid comes 16 edges after re-enable and counts only new samples.
- Window in progress with isi=7; pulse rst_n low between clock edges → rate=0, isi=0, both valids 0 before the next edge. After release, counting restarts from sample 1.
